// File: rtl/dispatch_ctrl_pkg.sv
// Shared types and widths for the decode-to-issue dispatch sequencer.
// Widths mirror the core-wide WORD/PC/ROB settings; unit codes follow the ID encoding.
package dispatch_ctrl_pkg;

  localparam int WORD_WIDTH        = 32;
  localparam int PC_WIDTH          = 32;
  localparam int ROB_DEPTH         = 16;
  localparam int DATA_WIDTH_ALU_OP = 8;
  localparam int NUM_WB            = 4;

  typedef enum logic [1:0] {
    UNIT_ALU = 2'd0,
    UNIT_MUL = 2'd1,
    UNIT_DIV = 2'd2,
    UNIT_LSU = 2'd3
  } unit_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  function automatic logic [3:0] unit_onehot(unit_e u);
    return 4'b0001 << u;
  endfunction

endpackage

// File: rtl/dispatch_ctrl_wakeup_snoop.sv
// Combinational tag match of one source operand against the four writeback buses.
// Bus index 0 is ALU, then MUL, DIV, LOAD; a lower index wins on multiple matches.
module dispatch_wakeup_snoop
  import dispatch_ctrl_pkg::*;
#(
  parameter int TAG_W = $clog2(ROB_DEPTH)
) (
  input  logic                               pending,
  input  logic [TAG_W-1:0]                   paddr,
  input  logic [NUM_WB-1:0]                  wb_valid,
  input  logic [NUM_WB-1:0][TAG_W-1:0]       wb_dst,
  input  logic [NUM_WB-1:0][WORD_WIDTH-1:0]  wb_data,
  output logic                               hit,
  output logic [WORD_WIDTH-1:0]              value
);

  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    hit   = 1'b0;
    value = '0;
    // Scan from lowest priority upward so the highest-priority match is the last write.
    for (int i = NUM_WB - 1; i >= 0; i--) begin
      if (pending && wb_valid[i] && (wb_dst[i] == paddr)) begin
        hit   = 1'b1;
        value = wb_data[i];
      end
    end
  end

endmodule

// File: rtl/dispatch_ctrl.sv
// Dispatch sequencer: one-entry output register steering renamed insns to ALU/MUL/DIV/LSU queues.
// Optional DISPATCH_PERF_CNT_EN adds dispatch and stall performance counters.
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
#(
  parameter int OP_WIDTH = DATA_WIDTH_ALU_OP,
  parameter int TAG_W    = $clog2(ROB_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [1:0]            id_unit,
  input  logic [OP_WIDTH-1:0]   id_op,
  input  logic [PC_WIDTH-1:0]   id_pc,
  input  logic [WORD_WIDTH-1:0] id_imm,
  input  logic                  rs1_rat_valid,
  input  logic                  rs2_rat_valid,
  input  logic [TAG_W-1:0]      rs1_Paddr,
  input  logic [TAG_W-1:0]      rs2_Paddr,
  input  logic [WORD_WIDTH-1:0] rs1_value_fromGPR,
  input  logic [WORD_WIDTH-1:0] rs2_value_fromGPR,
  input  logic [TAG_W-1:0]      rob_tag_in,
  input  logic                  rob_full,
  output logic                  rob_alloc_en,
  input  logic                  wb_alu_valid,
  input  logic [TAG_W-1:0]      wb_alu_dst_Paddr,
  input  logic [WORD_WIDTH-1:0] wb_alu_out,
  input  logic                  wb_mul_valid,
  input  logic [TAG_W-1:0]      wb_mul_dst_Paddr,
  input  logic [WORD_WIDTH-1:0] wb_mul_out,
  input  logic                  wb_div_valid,
  input  logic [TAG_W-1:0]      wb_div_dst_Paddr,
  input  logic [WORD_WIDTH-1:0] wb_div_out,
  input  logic                  wb_load_valid,
  input  logic [TAG_W-1:0]      wb_load_dst_Paddr,
  input  logic [WORD_WIDTH-1:0] wb_load_out,
  input  logic                  alu_queue_full,
  input  logic                  mul_queue_full,
  input  logic                  div_queue_full,
  input  logic                  lsu_queue_full,
  output logic                  issue2alu_en,
  output logic                  issue2mul_en,
  output logic                  issue2div_en,
  output logic                  issue2lsu_en,
  output logic [OP_WIDTH-1:0]   dq_op,
  output logic [PC_WIDTH-1:0]   dq_pc,
  output logic [WORD_WIDTH-1:0] dq_imm,
  output logic [TAG_W-1:0]      dq_alloc_rob,
  output logic                  dq_rs1_rat_valid,
  output logic                  dq_rs2_rat_valid,
  output logic [TAG_W-1:0]      dq_rs1_Paddr,
  output logic [TAG_W-1:0]      dq_rs2_Paddr,
  output logic [WORD_WIDTH-1:0] dq_rs1_value,
  output logic [WORD_WIDTH-1:0] dq_rs2_value,
  input  logic                  rob_commit_branch_taken,
  input  logic                  rob_commit_exp_en
`ifdef DISPATCH_PERF_CNT_EN
  ,
  output logic [31:0]           perf_dispatch_cnt,
  output logic [31:0]           perf_stall_cnt
`endif
);

  typedef struct packed {
    logic                  valid;
    unit_e                 unit;
    logic [OP_WIDTH-1:0]   op;
    logic [PC_WIDTH-1:0]   pc;
    logic [WORD_WIDTH-1:0] imm;
    logic [TAG_W-1:0]      rob;
    logic                  rs1_pend;
    logic [TAG_W-1:0]      rs1_tag;
    logic [WORD_WIDTH-1:0] rs1_val;
    logic                  rs2_pend;
    logic [TAG_W-1:0]      rs2_tag;
    logic [WORD_WIDTH-1:0] rs2_val;
  } ent_t;

  ent_t   ent;
  ent_t   id_ent;
  state_e state;
  logic   armed;

  logic                                flush, fire, accept, tgt_full;
  logic [3:0]                          q_full, en_vec;
  logic [NUM_WB-1:0]                   wb_valid;
  logic [NUM_WB-1:0][TAG_W-1:0]        wb_dst;
  logic [NUM_WB-1:0][WORD_WIDTH-1:0]   wb_data;
  logic                                e1_hit, e2_hit, i1_hit, i2_hit;
  logic [WORD_WIDTH-1:0]               e1_val, e2_val, i1_val, i2_val;

  assign wb_valid = {wb_load_valid, wb_div_valid, wb_mul_valid, wb_alu_valid};
  assign wb_dst   = {wb_load_dst_Paddr, wb_div_dst_Paddr, wb_mul_dst_Paddr, wb_alu_dst_Paddr};
  assign wb_data  = {wb_load_out, wb_div_out, wb_mul_out, wb_alu_out};

  // Two snoops track the held entry, two resolve operands of the insn being accepted.
  dispatch_wakeup_snoop #(.TAG_W(TAG_W)) u_snoop_ent_rs1 (
    .pending(ent.rs1_pend), .paddr(ent.rs1_tag), .wb_valid(wb_valid), .wb_dst(wb_dst),
    .wb_data(wb_data), .hit(e1_hit), .value(e1_val));
  dispatch_wakeup_snoop #(.TAG_W(TAG_W)) u_snoop_ent_rs2 (
    .pending(ent.rs2_pend), .paddr(ent.rs2_tag), .wb_valid(wb_valid), .wb_dst(wb_dst),
    .wb_data(wb_data), .hit(e2_hit), .value(e2_val));
  dispatch_wakeup_snoop #(.TAG_W(TAG_W)) u_snoop_id_rs1 (
    .pending(rs1_rat_valid), .paddr(rs1_Paddr), .wb_valid(wb_valid), .wb_dst(wb_dst),
    .wb_data(wb_data), .hit(i1_hit), .value(i1_val));
  dispatch_wakeup_snoop #(.TAG_W(TAG_W)) u_snoop_id_rs2 (
    .pending(rs2_rat_valid), .paddr(rs2_Paddr), .wb_valid(wb_valid), .wb_dst(wb_dst),
    .wb_data(wb_data), .hit(i2_hit), .value(i2_val));

  assign flush    = rob_commit_branch_taken | rob_commit_exp_en;
  assign q_full   = {lsu_queue_full, div_queue_full, mul_queue_full, alu_queue_full};
  assign tgt_full = q_full[ent.unit];
  assign en_vec   = (ent.valid && !tgt_full && !flush) ? unit_onehot(ent.unit) : 4'b0000;
  assign fire     = |en_vec;

  assign issue2alu_en = en_vec[UNIT_ALU];
  assign issue2mul_en = en_vec[UNIT_MUL];
  assign issue2div_en = en_vec[UNIT_DIV];
  assign issue2lsu_en = en_vec[UNIT_LSU];

  // armed stays low from reset until the first clock edge after release.
  assign id_ready     = armed && (!ent.valid || fire) && !rob_full && !flush && (state != ST_FLUSH);
  assign accept       = id_valid && id_ready;
  assign rob_alloc_en = accept;

  always_comb begin
    id_ent          = '0;
    id_ent.valid    = 1'b1;
    id_ent.unit     = unit_e'(id_unit);
    id_ent.op       = id_op;
    id_ent.pc       = id_pc;
    id_ent.imm      = id_imm;
    id_ent.rob      = rob_tag_in;
    id_ent.rs1_pend = rs1_rat_valid && !i1_hit;
    id_ent.rs1_tag  = rs1_Paddr;
    id_ent.rs1_val  = i1_hit ? i1_val : rs1_value_fromGPR;
    id_ent.rs2_pend = rs2_rat_valid && !i2_hit;
    id_ent.rs2_tag  = rs2_Paddr;
    id_ent.rs2_val  = i2_hit ? i2_val : rs2_value_fromGPR;
  end

  assign dq_op            = ent.op;
  assign dq_pc            = ent.pc;
  assign dq_imm           = ent.imm;
  assign dq_alloc_rob     = ent.rob;
  assign dq_rs1_Paddr     = ent.rs1_tag;
  assign dq_rs2_Paddr     = ent.rs2_tag;
  // A wakeup landing on the fire cycle is forwarded straight onto the payload bus.
  assign dq_rs1_rat_valid = ent.rs1_pend && !(fire && e1_hit);
  assign dq_rs1_value     = (fire && e1_hit) ? e1_val : ent.rs1_val;
  assign dq_rs2_rat_valid = ent.rs2_pend && !(fire && e2_hit);
  assign dq_rs2_value     = (fire && e2_hit) ? e2_val : ent.rs2_val;

  // NOTE: sequential state is written only with non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent   <= '0;
      state <= ST_IDLE;
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (flush) begin
        ent.valid <= 1'b0;
        state     <= ST_FLUSH;
      end else if (accept) begin
        ent   <= id_ent;
        state <= ST_SEND;
      end else if (fire) begin
        ent.valid <= 1'b0;
        state     <= ST_IDLE;
      end else if (ent.valid) begin
        if (e1_hit) begin
          ent.rs1_pend <= 1'b0;
          ent.rs1_val  <= e1_val;
        end
        if (e2_hit) begin
          ent.rs2_pend <= 1'b0;
          ent.rs2_val  <= e2_val;
        end
        state <= ST_WAIT;
      end else begin
        state <= ST_IDLE;
      end
    end
  end

`ifdef DISPATCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_dispatch_cnt <= '0;
      perf_stall_cnt    <= '0;
    end else begin
      if (fire)
        perf_dispatch_cnt <= perf_dispatch_cnt + 32'd1;
      if ((ent.valid && tgt_full) || (rob_full && id_valid))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed self-checking bench for dispatch_ctrl with a scoreboard of expected dispatches.
module tb_dispatch_ctrl;
  import dispatch_ctrl_pkg::*;

  localparam int OPW = DATA_WIDTH_ALU_OP;
  localparam int TW  = $clog2(ROB_DEPTH);

  typedef struct {
    logic [1:0]            unit;
    logic [OPW-1:0]        op;
    logic [PC_WIDTH-1:0]   pc;
    logic [WORD_WIDTH-1:0] imm;
    logic [TW-1:0]         rob;
    logic                  rs1_rv;
    logic [WORD_WIDTH-1:0] rs1_v;
    logic                  rs2_rv;
    logic [WORD_WIDTH-1:0] rs2_v;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_ready, rs1_rat_valid, rs2_rat_valid, rob_full, rob_alloc_en;
  logic [1:0] id_unit;
  logic [OPW-1:0] id_op, dq_op;
  logic [PC_WIDTH-1:0] id_pc, dq_pc;
  logic [WORD_WIDTH-1:0] id_imm, rs1_value_fromGPR, rs2_value_fromGPR, dq_imm, dq_rs1_value, dq_rs2_value;
  logic [TW-1:0] rs1_Paddr, rs2_Paddr, rob_tag_in, dq_alloc_rob, dq_rs1_Paddr, dq_rs2_Paddr;
  logic wb_alu_valid, wb_mul_valid, wb_div_valid, wb_load_valid;
  logic [TW-1:0] wb_alu_dst_Paddr, wb_mul_dst_Paddr, wb_div_dst_Paddr, wb_load_dst_Paddr;
  logic [WORD_WIDTH-1:0] wb_alu_out, wb_mul_out, wb_div_out, wb_load_out;
  logic alu_queue_full, mul_queue_full, div_queue_full, lsu_queue_full;
  logic issue2alu_en, issue2mul_en, issue2div_en, issue2lsu_en;
  logic dq_rs1_rat_valid, dq_rs2_rat_valid;
  logic rob_commit_branch_taken, rob_commit_exp_en;
`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0] perf_dispatch_cnt, perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  dispatch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready), .id_unit(id_unit),
    .id_op(id_op), .id_pc(id_pc), .id_imm(id_imm),
    .rs1_rat_valid(rs1_rat_valid), .rs2_rat_valid(rs2_rat_valid),
    .rs1_Paddr(rs1_Paddr), .rs2_Paddr(rs2_Paddr),
    .rs1_value_fromGPR(rs1_value_fromGPR), .rs2_value_fromGPR(rs2_value_fromGPR),
    .rob_tag_in(rob_tag_in), .rob_full(rob_full), .rob_alloc_en(rob_alloc_en),
    .wb_alu_valid(wb_alu_valid), .wb_alu_dst_Paddr(wb_alu_dst_Paddr), .wb_alu_out(wb_alu_out),
    .wb_mul_valid(wb_mul_valid), .wb_mul_dst_Paddr(wb_mul_dst_Paddr), .wb_mul_out(wb_mul_out),
    .wb_div_valid(wb_div_valid), .wb_div_dst_Paddr(wb_div_dst_Paddr), .wb_div_out(wb_div_out),
    .wb_load_valid(wb_load_valid), .wb_load_dst_Paddr(wb_load_dst_Paddr), .wb_load_out(wb_load_out),
    .alu_queue_full(alu_queue_full), .mul_queue_full(mul_queue_full),
    .div_queue_full(div_queue_full), .lsu_queue_full(lsu_queue_full),
    .issue2alu_en(issue2alu_en), .issue2mul_en(issue2mul_en),
    .issue2div_en(issue2div_en), .issue2lsu_en(issue2lsu_en),
    .dq_op(dq_op), .dq_pc(dq_pc), .dq_imm(dq_imm), .dq_alloc_rob(dq_alloc_rob),
    .dq_rs1_rat_valid(dq_rs1_rat_valid), .dq_rs2_rat_valid(dq_rs2_rat_valid),
    .dq_rs1_Paddr(dq_rs1_Paddr), .dq_rs2_Paddr(dq_rs2_Paddr),
    .dq_rs1_value(dq_rs1_value), .dq_rs2_value(dq_rs2_value),
    .rob_commit_branch_taken(rob_commit_branch_taken), .rob_commit_exp_en(rob_commit_exp_en)
`ifdef DISPATCH_PERF_CNT_EN
    , .perf_dispatch_cnt(perf_dispatch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  wire [3:0] en_vec = {issue2lsu_en, issue2div_en, issue2mul_en, issue2alu_en};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_unit = 0; id_op = 0; id_pc = 0; id_imm = 0;
    rs1_rat_valid = 0; rs2_rat_valid = 0; rs1_Paddr = 0; rs2_Paddr = 0;
    rs1_value_fromGPR = 0; rs2_value_fromGPR = 0; rob_tag_in = 0; rob_full = 0;
    wb_alu_valid = 0; wb_mul_valid = 0; wb_div_valid = 0; wb_load_valid = 0;
    wb_alu_dst_Paddr = 0; wb_mul_dst_Paddr = 0; wb_div_dst_Paddr = 0; wb_load_dst_Paddr = 0;
    wb_alu_out = 0; wb_mul_out = 0; wb_div_out = 0; wb_load_out = 0;
    alu_queue_full = 0; mul_queue_full = 0; div_queue_full = 0; lsu_queue_full = 0;
    rob_commit_branch_taken = 0; rob_commit_exp_en = 0;
  endtask

  task automatic wb_off();
    wb_alu_valid = 0; wb_mul_valid = 0; wb_div_valid = 0; wb_load_valid = 0;
  endtask

  task automatic drive_id(input logic [1:0] u, input logic [OPW-1:0] op, input logic [31:0] pc,
                          input logic [31:0] imm, input logic [TW-1:0] rob,
                          input logic r1, input logic [TW-1:0] p1, input logic [31:0] v1,
                          input logic r2, input logic [TW-1:0] p2, input logic [31:0] v2);
    id_valid = 1; id_unit = u; id_op = op; id_pc = pc; id_imm = imm; rob_tag_in = rob;
    rs1_rat_valid = r1; rs1_Paddr = p1; rs1_value_fromGPR = v1;
    rs2_rat_valid = r2; rs2_Paddr = p2; rs2_value_fromGPR = v2;
  endtask

  task automatic push_exp(input logic [1:0] u, input logic [OPW-1:0] op, input logic [31:0] pc,
                          input logic [31:0] imm, input logic [TW-1:0] rob,
                          input logic r1, input logic [31:0] v1, input logic r2, input logic [31:0] v2);
    exp_t e;
    e.unit = u; e.op = op; e.pc = pc; e.imm = imm; e.rob = rob;
    e.rs1_rv = r1; e.rs1_v = v1; e.rs2_rv = r2; e.rs2_v = v2;
    sb.push_back(e);
  endtask

  task automatic expect_issue(input string tag);
    exp_t e;
    logic [3:0] oh;
    if (sb.size() == 0) begin
      checks++; failures++;
      $error("FAIL %s_sb observed=empty_scoreboard expected=pending_entry", tag);
    end else begin
      e = sb.pop_front();
      oh = 4'b0001 << e.unit;
      check({tag, "_en"}, 64'(en_vec), 64'(oh));
      check({tag, "_op"}, 64'(dq_op), 64'(e.op));
      check({tag, "_pc"}, 64'(dq_pc), 64'(e.pc));
      check({tag, "_imm"}, 64'(dq_imm), 64'(e.imm));
      check({tag, "_rob"}, 64'(dq_alloc_rob), 64'(e.rob));
      check({tag, "_rs1rv"}, 64'(dq_rs1_rat_valid), 64'(e.rs1_rv));
      check({tag, "_rs1v"}, 64'(dq_rs1_value), 64'(e.rs1_v));
      check({tag, "_rs2rv"}, 64'(dq_rs2_rat_valid), 64'(e.rs2_rv));
      check({tag, "_rs2v"}, 64'(dq_rs2_value), 64'(e.rs2_v));
    end
  endtask

  task automatic check_quiet(input string tag, input logic rdy);
    check({tag, "_en"}, 64'(en_vec), 64'd0);
    check({tag, "_alloc"}, 64'(rob_alloc_en), 64'd0);
    check({tag, "_ready"}, 64'(id_ready), 64'(rdy));
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    #2;
    check_quiet("rst", 1'b0);
    check("rst_dq_op", 64'(dq_op), 64'd0);
    check("rst_dq_rs1v", 64'(dq_rs1_value), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1 check_quiet("rel", 1'b0);

    // Simple ALU dispatch, one cycle after accept.
    @(negedge clk);
    drive_id(UNIT_ALU, 8'h11, 32'h100, 32'h5, 4'd0, 0, 4'd0, 32'd10, 0, 4'd0, 32'd20);
    #1 check("t1_ready", 64'(id_ready), 64'd1);
    check("t1_alloc", 64'(rob_alloc_en), 64'd1);
    check("t1_en0", 64'(en_vec), 64'd0);
    push_exp(UNIT_ALU, 8'h11, 32'h100, 32'h5, 4'd0, 0, 32'd10, 0, 32'd20);
    @(negedge clk);
    id_valid = 0;
    #1 expect_issue("t1");
    @(negedge clk);
    #1 check_quiet("t1_empty", 1'b1);

    // MUL held for three cycles by a full queue, ALU waiting behind it.
    @(negedge clk);
    mul_queue_full = 1;
    drive_id(UNIT_MUL, 8'h22, 32'h200, 32'h7, 4'd1, 0, 4'd0, 32'd3, 0, 4'd0, 32'd4);
    #1 check("t2_alloc", 64'(rob_alloc_en), 64'd1);
    push_exp(UNIT_MUL, 8'h22, 32'h200, 32'h7, 4'd1, 0, 32'd3, 0, 32'd4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_id(UNIT_ALU, 8'h33, 32'h300, 32'h9, 4'd2, 0, 4'd0, 32'd5, 0, 4'd0, 32'd6);
      #1 check_quiet($sformatf("t2_wait%0d", i), 1'b0);
      check($sformatf("t2_pc%0d", i), 64'(dq_pc), 64'h200);
    end
    @(negedge clk);
    mul_queue_full = 0;
    #1 expect_issue("t2_mul");
    check("t2_b2b_alloc", 64'(rob_alloc_en), 64'd1);
    push_exp(UNIT_ALU, 8'h33, 32'h300, 32'h9, 4'd2, 0, 32'd5, 0, 32'd6);
    @(negedge clk);
    id_valid = 0;
    #1 expect_issue("t2_alu");

    // Wakeup of a held entry from the ALU writeback bus.
    @(negedge clk);
    alu_queue_full = 1;
    drive_id(UNIT_ALU, 8'h44, 32'h400, 32'h1, 4'd3, 1, 4'd2, 32'd99, 0, 4'd0, 32'd8);
    #1 check("t3_alloc", 64'(rob_alloc_en), 64'd1);
    push_exp(UNIT_ALU, 8'h44, 32'h400, 32'h1, 4'd3, 0, 32'd36, 0, 32'd8);
    @(negedge clk);
    id_valid = 0;
    wb_alu_valid = 1; wb_alu_dst_Paddr = 4'd2; wb_alu_out = 32'd36;
    #1 check("t3_hold_rv", 64'(dq_rs1_rat_valid), 64'd1);
    check("t3_hold_en", 64'(en_vec), 64'd0);
    @(negedge clk);
    wb_off();
    #1 check("t3_woke_rv", 64'(dq_rs1_rat_valid), 64'd0);
    check("t3_woke_v", 64'(dq_rs1_value), 64'd36);
    @(negedge clk);
    alu_queue_full = 0;
    #1 expect_issue("t3");

    // Load writeback resolves rs2 on the accept cycle.
    @(negedge clk);
    drive_id(UNIT_LSU, 8'h55, 32'h500, 32'h2, 4'd4, 0, 4'd5, 32'd1, 1, 4'd5, 32'hdead);
    wb_load_valid = 1; wb_load_dst_Paddr = 4'd5; wb_load_out = 32'habcd;
    #1 check("t4_alloc", 64'(rob_alloc_en), 64'd1);
    push_exp(UNIT_LSU, 8'h55, 32'h500, 32'h2, 4'd4, 0, 32'd1, 0, 32'habcd);
    @(negedge clk);
    id_valid = 0;
    wb_off();
    #1 expect_issue("t4");

    // Fire-cycle bypass with MUL beating LOAD on the same tag.
    @(negedge clk);
    drive_id(UNIT_DIV, 8'h66, 32'h600, 32'h3, 4'd5, 1, 4'd7, 32'd0, 1, 4'd9, 32'd0);
    #1 check("tp_alloc", 64'(rob_alloc_en), 64'd1);
    push_exp(UNIT_DIV, 8'h66, 32'h600, 32'h3, 4'd5, 0, 32'h77, 1, 32'd0);
    @(negedge clk);
    id_valid = 0;
    wb_mul_valid = 1; wb_mul_dst_Paddr = 4'd7; wb_mul_out = 32'h77;
    wb_load_valid = 1; wb_load_dst_Paddr = 4'd7; wb_load_out = 32'h88;
    wb_div_valid = 1; wb_div_dst_Paddr = 4'd3; wb_div_out = 32'h33;
    #1 expect_issue("tp");

    // Branch flush drops the held entry and blocks the simultaneous accept.
    @(negedge clk);
    wb_off();
    alu_queue_full = 1;
    drive_id(UNIT_ALU, 8'h77, 32'h700, 32'h4, 4'd6, 0, 4'd0, 32'd1, 0, 4'd0, 32'd2);
    #1 check("t5_alloc", 64'(rob_alloc_en), 64'd1);
    push_exp(UNIT_ALU, 8'h77, 32'h700, 32'h4, 4'd6, 0, 32'd1, 0, 32'd2);
    @(negedge clk);
    alu_queue_full = 0;
    rob_commit_branch_taken = 1;
    drive_id(UNIT_ALU, 8'h88, 32'h800, 32'h6, 4'd7, 0, 4'd0, 32'd3, 0, 4'd0, 32'd4);
    #1 check_quiet("t5_flush", 1'b0);
    void'(sb.pop_front());
    @(negedge clk);
    rob_commit_branch_taken = 0;
    #1 check_quiet("t5_fcyc", 1'b0);
    @(negedge clk);
    #1 check("t5_ready", 64'(id_ready), 64'd1);
    check("t5_alloc2", 64'(rob_alloc_en), 64'd1);
    push_exp(UNIT_ALU, 8'h88, 32'h800, 32'h6, 4'd7, 0, 32'd3, 0, 32'd4);
    @(negedge clk);
    id_valid = 0;
    #1 expect_issue("t5_post");

    // Four back-to-back dispatches, one per unit.
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i < 4) drive_id(2'(i), 8'(8'h90 + i), 32'(32'h900 + 4 * i), 32'(i), 4'(8 + i),
                          0, 4'd0, 32'(i), 0, 4'd0, 32'(100 + i));
      else id_valid = 0;
      #1;
      if (i > 0) expect_issue($sformatf("t6_%0d", i - 1));
      if (i < 4) begin
        check($sformatf("t6_alloc%0d", i), 64'(rob_alloc_en), 64'd1);
        push_exp(2'(i), 8'(8'h90 + i), 32'(32'h900 + 4 * i), 32'(i), 4'(8 + i), 0, 32'(i), 0, 32'(100 + i));
      end
    end

    // Reset asserted mid-stream clears outputs without waiting for a clock.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive_id(2'(i), 8'(8'ha0 + i), 32'(32'ha00 + i), 32'd0, 4'(i), 0, 4'd0, 32'd1, 0, 4'd0, 32'd2);
      #1;
      if (i > 0) expect_issue("t7_pre");
      push_exp(2'(i), 8'(8'ha0 + i), 32'(32'ha00 + i), 32'd0, 4'(i), 0, 32'd1, 0, 32'd2);
    end
    @(negedge clk);
    drive_id(UNIT_DIV, 8'hb0, 32'hb00, 32'd0, 4'd2, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0);
    #1 expect_issue("t7_mul");
    #1 rst_n = 0;
    sb.delete();
    #1 check_quiet("t7_rst", 1'b0);
    check("t7_dq_op", 64'(dq_op), 64'd0);
    check("t7_dq_pc", 64'(dq_pc), 64'd0);
    check("t7_dq_rob", 64'(dq_alloc_rob), 64'd0);
    @(negedge clk);
    rst_n = 1;
    clear_inputs();
    #1 check_quiet("t7_rel", 1'b0);
    @(negedge clk);
    #1 check_quiet("t7_idle", 1'b1);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
